inst_fetch_loader: RTL and testbench
====================================

Name: inst_fetch_loader

Overview:
- Second-generation instruction fetch stage with an integrated byte-serial program loader.
- Owns a private 2^ADDR_WIDTH x 32-bit instruction RAM.
- Load side: assembles UART-style 8-bit loader bytes into words, with selectable endianness, and writes them sequentially from address 0.
- Fetch side: serves pipelined, stallable fetches to the decode stage, each tagged with its PC.
- Sits between the program loader front end and the decode stage.

Parameters:
- ADDR_WIDTH, 12, word-address width; RAM depth = 2^ADDR_WIDTH.
- BIG_ENDIAN, 1, 1 = first received byte goes to inst[31:24]; 0 = first byte goes to inst[7:0].

Ports:
- CLK  in  1  clock.
- reset  in  1  synchronous, active-high reset, sampled on posedge CLK.
- pc  in  ADDR_WIDTH  fetch word address.
- fetch_req  in  1  request a fetch at pc this cycle.
- stall  in  1  downstream stall; hold fetch outputs.
- input_data  in  8  loader byte.
- input_valid  in  1  input_data valid this cycle (single-cycle pulse per byte).
- input_start  in  1  begin program load.
- input_end  in  1  end program load.
- inst  out  32  fetched instruction.
- inst_valid  out  1  inst/inst_pc valid.
- inst_pc  out  ADDR_WIDTH  address inst was read from.
- loading  out  1  high while in LOAD state.
- load_count  out  ADDR_WIDTH+1  words written in the current/last load.
- load_partial  out  1  last load ended with an incomplete word.
- load_overflow  out  1  bytes arrived after the RAM was full.

Behaviour:
- Reset values:
  - State IDLE; inst = 0, inst_valid = 0, inst_pc = 0, loading = 0, load_count = 0, load_partial = 0, load_overflow = 0.
  - Byte counter = 0, write address = 0.
  - RAM contents are not cleared.
- FSM states:
  - IDLE: no program loaded. fetch_req is ignored; inst_valid stays 0.
  - LOAD: loading = 1.
  - RUN: fetches are served.
- Transitions:
  - IDLE/RUN --input_start--> LOAD.
  - LOAD --input_start--> LOAD (restart).
  - LOAD --input_end--> RUN.
  - reset overrides all transitions, from any state.
- On entry to LOAD (including restart): clear write address, byte counter, load_count, load_partial and load_overflow. Force inst_valid = 0 on the next edge.
- Byte assembly:
  - Each input_valid in LOAD stores a byte into lane byte_cnt (lane order per BIG_ENDIAN); byte_cnt++.
  - On the 4th byte, write the word to RAM[waddr] that same edge; waddr++, load_count++, byte_cnt = 0.
  - input_valid outside LOAD is ignored.
- Simultaneous input_valid and input_end: the byte is accepted first, then end processing runs in the same edge.
- End processing:
  - If byte_cnt != 0, zero-fill the unwritten lanes, write the word, load_count++, load_partial = 1.
  - Go to RUN.
- Overflow: once load_count = 2^ADDR_WIDTH, further bytes and partial writes are dropped and load_overflow = 1. Sticky until the next input_start or reset. No address wrap.
- input_start and input_end together: input_start wins.
- Fetch in RUN:
  - With stall = 0: fetch_req at edge N gives inst = RAM[pc], inst_pc = pc, inst_valid = 1 after edge N+1 (1-cycle synchronous-read latency).
  - fetch_req = 0 with stall = 0: inst_valid = 0 next cycle.
  - stall = 1: inst, inst_pc and inst_valid hold their values; fetch_req is ignored.
- Read-during-write cannot occur: fetch is disabled in LOAD.
- Reset mid-load: return to IDLE. Any partial word is discarded and the RAM keeps the words already written.

Decomposition:
- Shared package if_pkg:
  - loader FSM state enum (IDLE, LOAD, RUN).
  - INST_WIDTH = 32, BYTES_PER_INST = 4.
  - NOP encoding, for downstream use only.
- One sub-module, inst_ram:
  - Single-port synchronous-read RAM, parameter ADDR_WIDTH.
  - Ports: CLK, we, addr, wdata, rdata.
  - Address mux: write address in LOAD, pc otherwise.

Test Plan:
- Basic load and fetch:
  - Stimulus: reset; input_start; bytes 0x12,0x34,0x56,0x78,0x9A,0xBC,0xDE,0xF0; input_end; fetch pc=0 then pc=1.
  - Response: load_count=2; inst=0x12345678, inst_pc=0, then inst=0x9ABCDEF0, inst_pc=1; each valid 1 cycle after its request.
- Little-endian build:
  - Stimulus: BIG_ENDIAN=0, same 4 bytes 0x12,0x34,0x56,0x78.
  - Response: RAM[0]=0x78563412.
- Partial word with simultaneous end:
  - Stimulus: 6 bytes AA,BB,CC,DD,EE,FF, with input_end asserted in the same cycle as 0xFF.
  - Response: RAM[1]=0xEEFF0000 (big-endian), load_count=2, load_partial=1.
- Stall:
  - Stimulus: fetch pc=3, then stall=1 for 3 cycles with fetch_req=1, pc=4.
  - Response: inst and inst_pc=3 held with inst_valid=1; pc=4 result appears 1 cycle after stall drops.
- Overflow:
  - Stimulus: ADDR_WIDTH=2; load 5 words.
  - Response: load_count=4, load_overflow=1, RAM[0] equals the first word (no wrap).
- Reset/restart mid-load:
  - Stimulus: reset after 2 bytes.
  - Response: IDLE, fetch_req ignored (inst_valid stays 0).
  - Stimulus: input_start during LOAD.
  - Response: load_count returns to 0, next word written at address 0.

Source files
------------

// File: rtl/inst_fetch_loader_pkg.sv
// Shared types and constants for the instruction fetch stage and its program loader.
package if_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } ld_state_t;

    localparam int INST_WIDTH     = 32;
    localparam int BYTES_PER_INST = 4;

    // Canonical no-op (addi x0,x0,0) handed to decode when it needs a bubble.
    localparam logic [INST_WIDTH-1:0] NOP = 32'h0000_0013;

    // Bit offset of the lane that receives the idx-th byte of a word.
    function automatic logic [4:0] lane_shift(input logic [1:0] idx, input logic big_endian);
        return big_endian ? {~idx, 3'b000} : {idx, 3'b000};
    endfunction

endpackage

// File: rtl/inst_fetch_loader_if.sv
// Fetch and loader signal bundle between the loader front end / decode and the fetch stage.
interface inst_fetch_loader_if #(parameter int ADDR_WIDTH = 12);

    logic [ADDR_WIDTH-1:0] pc;
    logic                  fetch_req;
    logic                  stall;
    logic [7:0]            input_data;
    logic                  input_valid;
    logic                  input_start;
    logic                  input_end;
    logic [31:0]           inst;
    logic                  inst_valid;
    logic [ADDR_WIDTH-1:0] inst_pc;
    logic                  loading;
    logic [ADDR_WIDTH:0]   load_count;
    logic                  load_partial;
    logic                  load_overflow;

    modport master (
        output pc, fetch_req, stall, input_data, input_valid, input_start, input_end,
        input  inst, inst_valid, inst_pc, loading, load_count, load_partial, load_overflow
    );

    modport slave (
        input  pc, fetch_req, stall, input_data, input_valid, input_start, input_end,
        output inst, inst_valid, inst_pc, loading, load_count, load_partial, load_overflow
    );

endinterface

// File: rtl/inst_fetch_loader_ram.sv
// Single-port instruction RAM with synchronous read; contents are never reset.
module inst_ram
    import if_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  CLK,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [INST_WIDTH-1:0] wdata,
    output logic [INST_WIDTH-1:0] rdata
);

    logic [INST_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/inst_fetch_loader.sv
// Fetch stage with a byte-serial loader that fills the private instruction RAM from address 0.
module inst_fetch_loader
    import if_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic              CLK,
    input  logic              reset,
    inst_fetch_loader_if.slave bus
);

    ld_state_t             state, next_state;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [1:0]            byte_cnt;
    logic [2:0]            cnt_after;
    logic [INST_WIDTH-1:0] word_buf;
    logic [INST_WIDTH-1:0] asm_word;
    logic [INST_WIDTH-1:0] rdata;
    logic [ADDR_WIDTH:0]   load_count;
    logic                  load_partial;
    logic                  load_overflow;
    logic                  inst_valid;
    logic [ADDR_WIDTH-1:0] inst_pc;
    logic                  full, byte_in, accept, overflow_set;
    logic                  word_done, end_now, partial_flush, we;

    always_ff @(posedge CLK) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (bus.input_start) begin
            next_state = LOAD;
        end else if (state == LOAD && bus.input_end) begin
            next_state = RUN;
        end
    end

    // word_buf is kept zeroed in lanes not yet filled, so a partial word is flushed as-is.
    always_comb begin
        full         = load_count[ADDR_WIDTH];
        byte_in      = (state == LOAD) && bus.input_valid && !bus.input_start;
        accept       = byte_in && !full;
        overflow_set = byte_in && full;
        asm_word     = word_buf;
        if (accept) begin
            asm_word[lane_shift(byte_cnt, BIG_ENDIAN) +: 8] = bus.input_data;
        end
        cnt_after     = {1'b0, byte_cnt} + {2'b00, accept};
        word_done     = (cnt_after == 3'(BYTES_PER_INST));
        end_now       = (state == LOAD) && bus.input_end && !bus.input_start;
        partial_flush = end_now && !word_done && (cnt_after != 3'd0);
        we            = (word_done || partial_flush) && !reset;
        ram_addr      = (state == LOAD) ? waddr : (bus.stall ? inst_pc : bus.pc);
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            waddr         <= '0;
            byte_cnt      <= '0;
            word_buf      <= '0;
            load_count    <= '0;
            load_partial  <= 1'b0;
            load_overflow <= 1'b0;
        end else if (bus.input_start) begin
            waddr         <= '0;
            byte_cnt      <= '0;
            word_buf      <= '0;
            load_count    <= '0;
            load_partial  <= 1'b0;
            load_overflow <= 1'b0;
        end else if (state == LOAD) begin
            if (overflow_set) begin
                load_overflow <= 1'b1;
            end
            if (we) begin
                waddr      <= waddr + 1'b1;
                load_count <= load_count + 1'b1;
            end
            if (end_now || word_done) begin
                byte_cnt <= '0;
                word_buf <= '0;
                if (partial_flush) begin
                    load_partial <= 1'b1;
                end
            end else if (accept) begin
                byte_cnt <= byte_cnt + 1'b1;
                word_buf <= asm_word;
            end
        end
    end

    // While stalled the RAM re-reads the held address, so rdata stays stable without a second register.
    always_ff @(posedge CLK) begin
        if (reset) begin
            inst_valid <= 1'b0;
            inst_pc    <= '0;
        end else if (bus.input_start || state != RUN) begin
            inst_valid <= 1'b0;
        end else if (!bus.stall) begin
            inst_valid <= bus.fetch_req;
            if (bus.fetch_req) begin
                inst_pc <= bus.pc;
            end
        end
    end

    inst_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
        .CLK   (CLK),
        .we    (we),
        .addr  (ram_addr),
        .wdata (asm_word),
        .rdata (rdata)
    );

    assign bus.inst          = inst_valid ? rdata : '0;
    assign bus.inst_valid    = inst_valid;
    assign bus.inst_pc       = inst_pc;
    assign bus.loading       = (state == LOAD);
    assign bus.load_count    = load_count;
    assign bus.load_partial  = load_partial;
    assign bus.load_overflow = load_overflow;

endmodule

// File: tb/tb_inst_fetch_loader.sv
// Directed bench driving three builds (big-endian, little-endian, 4-word RAM) from one stimulus stream.
module tb_inst_fetch_loader;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] pc = '0;
    logic        fetch_req = 1'b0;
    logic        stall = 1'b0;
    logic [7:0]  input_data = '0;
    logic        input_valid = 1'b0;
    logic        input_start = 1'b0;
    logic        input_end = 1'b0;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    inst_fetch_loader_if #(.ADDR_WIDTH(12)) be_if ();
    inst_fetch_loader_if #(.ADDR_WIDTH(12)) le_if ();
    inst_fetch_loader_if #(.ADDR_WIDTH(2))  sm_if ();

    assign be_if.pc = pc;        assign le_if.pc = pc;        assign sm_if.pc = pc[1:0];
    assign be_if.fetch_req = fetch_req;     assign le_if.fetch_req = fetch_req;     assign sm_if.fetch_req = fetch_req;
    assign be_if.stall = stall;             assign le_if.stall = stall;             assign sm_if.stall = stall;
    assign be_if.input_data = input_data;   assign le_if.input_data = input_data;   assign sm_if.input_data = input_data;
    assign be_if.input_valid = input_valid; assign le_if.input_valid = input_valid; assign sm_if.input_valid = input_valid;
    assign be_if.input_start = input_start; assign le_if.input_start = input_start; assign sm_if.input_start = input_start;
    assign be_if.input_end = input_end;     assign le_if.input_end = input_end;     assign sm_if.input_end = input_end;

    inst_fetch_loader #(.ADDR_WIDTH(12), .BIG_ENDIAN(1'b1)) dut_be (.CLK(CLK), .reset(reset), .bus(be_if.slave));
    inst_fetch_loader #(.ADDR_WIDTH(12), .BIG_ENDIAN(1'b0)) dut_le (.CLK(CLK), .reset(reset), .bus(le_if.slave));
    inst_fetch_loader #(.ADDR_WIDTH(2),  .BIG_ENDIAN(1'b1)) dut_sm (.CLK(CLK), .reset(reset), .bus(sm_if.slave));

    task automatic step();
        @(negedge CLK);
    endtask

    task automatic send_byte(input logic [7:0] b);
        input_data  = b;
        input_valid = 1'b1;
        step();
        input_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic pulse_start();
        input_start = 1'b1;
        step();
        input_start = 1'b0;
    endtask

    task automatic pulse_end();
        input_end = 1'b1;
        step();
        input_end = 1'b0;
    endtask

    task automatic fetch(input logic [11:0] addr);
        pc        = addr;
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        n_cmp++; if (be_if.inst !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_inst: got %h expected %h", be_if.inst, 32'h0); end
        n_cmp++; if (be_if.inst_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b expected 0", be_if.inst_valid); end
        n_cmp++; if (be_if.inst_pc !== 12'h0) begin n_fail++; $display("[TB] FAIL reset_pc: got %h expected 0", be_if.inst_pc); end
        n_cmp++; if (be_if.loading !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_loading: got %b expected 0", be_if.loading); end
        n_cmp++; if (be_if.load_count !== 13'd0) begin n_fail++; $display("[TB] FAIL reset_count: got %0d expected 0", be_if.load_count); end
        n_cmp++; if ({be_if.load_partial, be_if.load_overflow} !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_flags: got %b expected 00", {be_if.load_partial, be_if.load_overflow}); end
        fetch(12'd5);
        n_cmp++; if (be_if.inst_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_fetch_ignored: got %b expected 0", be_if.inst_valid); end
    endtask

    task automatic test_basic_load();
        pulse_start();
        n_cmp++; if (be_if.loading !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_loading: got %b expected 1", be_if.loading); end
        send_word(32'h12345678);
        send_word(32'h9ABCDEF0);
        n_cmp++; if (be_if.load_count !== 13'd2) begin n_fail++; $display("[TB] FAIL basic_count: got %0d expected 2", be_if.load_count); end
        pulse_end();
        n_cmp++; if (be_if.loading !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_run: got %b expected 0", be_if.loading); end
        n_cmp++; if (be_if.load_partial !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_partial: got %b expected 0", be_if.load_partial); end
        n_cmp++; if (sm_if.load_count !== 3'd2) begin n_fail++; $display("[TB] FAIL basic_sm_count: got %0d expected 2", sm_if.load_count); end
        fetch(12'd0);
        n_cmp++; if (be_if.inst !== 32'h12345678) begin n_fail++; $display("[TB] FAIL basic_inst0: got %h expected %h", be_if.inst, 32'h12345678); end
        n_cmp++; if (be_if.inst_pc !== 12'd0 || be_if.inst_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_pc0: got pc %h valid %b expected pc 0 valid 1", be_if.inst_pc, be_if.inst_valid); end
        n_cmp++; if (le_if.inst !== 32'h78563412) begin n_fail++; $display("[TB] FAIL le_inst0: got %h expected %h", le_if.inst, 32'h78563412); end
        fetch(12'd1);
        n_cmp++; if (be_if.inst !== 32'h9ABCDEF0) begin n_fail++; $display("[TB] FAIL basic_inst1: got %h expected %h", be_if.inst, 32'h9ABCDEF0); end
        n_cmp++; if (be_if.inst_pc !== 12'd1) begin n_fail++; $display("[TB] FAIL basic_pc1: got %h expected 1", be_if.inst_pc); end
        n_cmp++; if (le_if.inst !== 32'hF0DEBC9A) begin n_fail++; $display("[TB] FAIL le_inst1: got %h expected %h", le_if.inst, 32'hF0DEBC9A); end
        step();
        n_cmp++; if (be_if.inst_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_no_req: got %b expected 0", be_if.inst_valid); end
    endtask

    task automatic test_partial_end();
        pulse_start();
        send_word(32'hAABBCCDD);
        send_byte(8'hEE);
        input_data  = 8'hFF;
        input_valid = 1'b1;
        input_end   = 1'b1;
        step();
        input_valid = 1'b0;
        input_end   = 1'b0;
        n_cmp++; if (be_if.load_count !== 13'd2) begin n_fail++; $display("[TB] FAIL partial_count: got %0d expected 2", be_if.load_count); end
        n_cmp++; if (be_if.load_partial !== 1'b1) begin n_fail++; $display("[TB] FAIL partial_flag: got %b expected 1", be_if.load_partial); end
        n_cmp++; if (be_if.loading !== 1'b0) begin n_fail++; $display("[TB] FAIL partial_run: got %b expected 0", be_if.loading); end
        fetch(12'd1);
        n_cmp++; if (be_if.inst !== 32'hEEFF0000) begin n_fail++; $display("[TB] FAIL partial_be_word: got %h expected %h", be_if.inst, 32'hEEFF0000); end
        n_cmp++; if (le_if.inst !== 32'h0000FFEE) begin n_fail++; $display("[TB] FAIL partial_le_word: got %h expected %h", le_if.inst, 32'h0000FFEE); end
    endtask

    task automatic test_overflow();
        pulse_start();
        send_word(32'h01020304);
        send_word(32'h11121314);
        send_word(32'h21222324);
        send_word(32'h31323334);
        send_word(32'h41424344);
        pulse_end();
        n_cmp++; if (sm_if.load_count !== 3'd4) begin n_fail++; $display("[TB] FAIL ovf_sm_count: got %0d expected 4", sm_if.load_count); end
        n_cmp++; if (sm_if.load_overflow !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf_sm_flag: got %b expected 1", sm_if.load_overflow); end
        n_cmp++; if (sm_if.load_partial !== 1'b0) begin n_fail++; $display("[TB] FAIL ovf_sm_partial: got %b expected 0", sm_if.load_partial); end
        n_cmp++; if (be_if.load_count !== 13'd5 || be_if.load_overflow !== 1'b0) begin n_fail++; $display("[TB] FAIL ovf_be_count: got %0d/%b expected 5/0", be_if.load_count, be_if.load_overflow); end
        fetch(12'd3);
        n_cmp++; if (sm_if.inst !== 32'h31323334) begin n_fail++; $display("[TB] FAIL ovf_sm_last: got %h expected %h", sm_if.inst, 32'h31323334); end
        fetch(12'd4);
        n_cmp++; if (sm_if.inst !== 32'h01020304) begin n_fail++; $display("[TB] FAIL ovf_no_wrap: got %h expected %h", sm_if.inst, 32'h01020304); end
        n_cmp++; if (be_if.inst !== 32'h41424344) begin n_fail++; $display("[TB] FAIL ovf_be_word4: got %h expected %h", be_if.inst, 32'h41424344); end
    endtask

    task automatic test_stall();
        fetch(12'd3);
        n_cmp++; if (be_if.inst !== 32'h31323334) begin n_fail++; $display("[TB] FAIL stall_pre: got %h expected %h", be_if.inst, 32'h31323334); end
        stall     = 1'b1;
        fetch_req = 1'b1;
        pc        = 12'd4;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (be_if.inst !== 32'h31323334 || be_if.inst_pc !== 12'd3 || be_if.inst_valid !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL stall_hold%0d: got %h pc %h valid %b expected 31323334 pc 3 valid 1", i, be_if.inst, be_if.inst_pc, be_if.inst_valid);
            end
        end
        stall = 1'b0;
        step();
        fetch_req = 1'b0;
        n_cmp++; if (be_if.inst !== 32'h41424344 || be_if.inst_pc !== 12'd4) begin n_fail++; $display("[TB] FAIL stall_release: got %h pc %h expected 41424344 pc 4", be_if.inst, be_if.inst_pc); end
    endtask

    task automatic test_restart();
        pulse_start();
        send_byte(8'h55);
        send_byte(8'h66);
        input_start = 1'b1;
        input_end   = 1'b1;
        step();
        input_start = 1'b0;
        input_end   = 1'b0;
        n_cmp++; if (be_if.loading !== 1'b1 || be_if.load_count !== 13'd0) begin n_fail++; $display("[TB] FAIL restart_state: got loading %b count %0d expected 1/0", be_if.loading, be_if.load_count); end
        send_word(32'hCAFEBABE);
        n_cmp++; if (be_if.load_count !== 13'd1) begin n_fail++; $display("[TB] FAIL restart_count: got %0d expected 1", be_if.load_count); end
        send_byte(8'h11);
        send_byte(8'h22);
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_cmp++; if (be_if.loading !== 1'b0 || be_if.load_count !== 13'd0) begin n_fail++; $display("[TB] FAIL midload_reset: got loading %b count %0d expected 0/0", be_if.loading, be_if.load_count); end
        fetch(12'd0);
        n_cmp++; if (be_if.inst_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL midload_idle_fetch: got %b expected 0", be_if.inst_valid); end
        pulse_start();
        pulse_end();
        fetch(12'd0);
        n_cmp++; if (be_if.inst !== 32'hCAFEBABE) begin n_fail++; $display("[TB] FAIL restart_addr0: got %h expected %h", be_if.inst, 32'hCAFEBABE); end
        fetch(12'd1);
        n_cmp++; if (be_if.inst !== 32'h11121314) begin n_fail++; $display("[TB] FAIL reset_kept_ram: got %h expected %h", be_if.inst, 32'h11121314); end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_partial_end();
        test_overflow();
        test_stall();
        test_restart();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
